// File: rtl/serial_rx_lane_if.sv
// Parallel-side and serial-input signals of one receive lane.
// master drives the serial stream and enable; slave is the receiver.
interface serial_rx_lane_if;
  logic       enable;
  logic       rx_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  modport master (
    output enable, rx_in,
    input  data_out, valid_out, byte_strobe, active
  );

  modport slave (
    input  enable, rx_in,
    output data_out, valid_out, byte_strobe, active
  );
endinterface

// File: rtl/serial_rx_lane.sv
// Single-lane serial receiver: comma hunt, lock after SYNC_COUNT aligned commas, byte output.
// Optional loss-of-sync detection in ACTIVE is built when SERIAL_RX_LOS_EN is defined.
module serial_rx_lane #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4
) (
  input logic             clk_8f,
  input logic             reset_L,
  serial_rx_lane_if.slave lane
);

  typedef enum logic [1:0] {SEARCH, COUNT, ACTIVE} state_t;

  localparam logic [3:0] SYNC_LIMIT = 4'(SYNC_COUNT);

  state_t     state_q, state_d;
  // Only the 7 newest bits are kept; the window is always formed with rx_in appended.
  logic [6:0] sr_q, sr_d;
  logic [2:0] bit_q, bit_d;
  logic [3:0] comma_q, comma_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;
  logic       active_q;
  logic [7:0] win;
  logic [3:0] comma_inc;
`ifdef SERIAL_RX_LOS_EN
  logic [1:0] los_q, los_d;
`endif

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= SEARCH;
      sr_q     <= '0;
      bit_q    <= '0;
      comma_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      active_q <= 1'b0;
`ifdef SERIAL_RX_LOS_EN
      los_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bit_q    <= bit_d;
      comma_q  <= comma_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
      active_q <= (state_d == ACTIVE);
`ifdef SERIAL_RX_LOS_EN
      los_q    <= los_d;
`endif
    end
  end

  always_comb begin
    win       = {sr_q, lane.rx_in};
    comma_inc = comma_q + 4'd1;
    state_d   = state_q;
    sr_d      = sr_q;
    bit_d     = bit_q;
    comma_d   = comma_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;
`ifdef SERIAL_RX_LOS_EN
    los_d     = los_q;
`endif
    if (!lane.enable) begin
      state_d = SEARCH;
      sr_d    = '0;
      bit_d   = '0;
      comma_d = '0;
      valid_d = 1'b0;
`ifdef SERIAL_RX_LOS_EN
      los_d   = '0;
`endif
    end else begin
      sr_d = win[6:0];
      unique case (state_q)
        SEARCH: begin
          if (win == COMMA) begin
            bit_d   = '0;
            comma_d = 4'd1;
            state_d = COUNT;
          end
        end
        COUNT: begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            if (win == COMMA) begin
              comma_d = comma_inc;
              if (comma_inc == SYNC_LIMIT) state_d = ACTIVE;
            end else begin
              comma_d = '0;
              state_d = SEARCH;
            end
          end
        end
        ACTIVE: begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            strobe_d = 1'b1;
            if (win == COMMA) begin
              valid_d = 1'b0;
            end else begin
              data_d  = win;
              valid_d = 1'b1;
            end
          end
`ifdef SERIAL_RX_LOS_EN
          // A comma seen off the frame boundary means the frame clock has slipped.
          if (win == COMMA) begin
            if (bit_q == 3'd7) begin
              los_d = '0;
            end else if (los_q == 2'd2) begin
              los_d    = '0;
              comma_d  = '0;
              valid_d  = 1'b0;
              strobe_d = 1'b0;
              state_d  = SEARCH;
            end else begin
              los_d = los_q + 2'd1;
            end
          end
`endif
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  assign lane.data_out    = data_q;
  assign lane.valid_out   = valid_q;
  assign lane.byte_strobe = strobe_q;
  assign lane.active      = active_q;

endmodule

// File: tb/tb_serial_rx_lane.sv
// Bench for serial_rx_lane: byte vector table plus hand-written sequences, strobe-driven scoreboard.
// Expectation for the loss-of-sync sequence depends on SERIAL_RX_LOS_EN.
module tb_serial_rx_lane;

  typedef struct {
    logic [7:0] b;
    logic       strobe;
    logic [7:0] d;
    logic       v;
    logic       act;
    int         lane;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       v;
  } exp_t;

`ifdef SERIAL_RX_LOS_EN
  localparam logic LOS_ACTIVE_EXP = 1'b0;
`else
  localparam logic LOS_ACTIVE_EXP = 1'b1;
`endif

  logic clk;
  logic reset_L;
  int   n_vec  = 0;
  int   n_fail = 0;
  vec_t vecs[34];
  exp_t q0[$];
  exp_t q1[$];
  int   cyc0 = 0, cyc1 = 0, last0 = -1, last1 = -1;

  serial_rx_lane_if ifa ();
  serial_rx_lane_if ifb ();

  serial_rx_lane u_dut (
    .clk_8f (clk),
    .reset_L(reset_L),
    .lane   (ifa)
  );

  serial_rx_lane #(.SYNC_COUNT(2)) u_dut2 (
    .clk_8f (clk),
    .reset_L(reset_L),
    .lane   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    cyc0++;
    if (ifa.byte_strobe) begin
      check("strobe_active0", int'(ifa.active), 1);
      check("strobe_expected0", int'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        exp_t e;
        e = q0.pop_front();
        check("data0", int'(ifa.data_out), int'(e.d));
        check("valid0", int'(ifa.valid_out), int'(e.v));
      end
      if (last0 >= 0) check("strobe_period0", cyc0 - last0, 8);
      last0 = cyc0;
    end
    if (!ifa.active) last0 = -1;
  end

  always @(posedge clk) begin
    #1;
    cyc1++;
    if (ifb.byte_strobe) begin
      check("strobe_active1", int'(ifb.active), 1);
      check("strobe_expected1", int'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        exp_t e;
        e = q1.pop_front();
        check("data1", int'(ifb.data_out), int'(e.d));
        check("valid1", int'(ifb.valid_out), int'(e.v));
      end
      if (last1 >= 0) check("strobe_period1", cyc1 - last1, 8);
      last1 = cyc1;
    end
    if (!ifb.active) last1 = -1;
  end

  task automatic send_bit(input int lane, input logic b);
    if (lane == 0) ifa.rx_in = b;
    else           ifb.rx_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input int lane, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(lane, b[i]);
  endtask

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      if (vecs[i].strobe) begin
        if (vecs[i].lane == 0) q0.push_back('{vecs[i].d, vecs[i].v});
        else                   q1.push_back('{vecs[i].d, vecs[i].v});
      end
      send_byte(vecs[i].lane, vecs[i].b);
      check($sformatf("active[%0d]", i),
            int'(vecs[i].lane == 0 ? ifa.active : ifb.active), int'(vecs[i].act));
    end
  endtask

  task automatic disable_lane0(input int cycles);
    ifa.enable = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    ifa.enable = 1'b1;
  endtask

  task automatic check_idle0(input string name, input logic [7:0] data_exp);
    check({name, "_active"}, int'(ifa.active), 0);
    check({name, "_valid"}, int'(ifa.valid_out), 0);
    check({name, "_strobe"}, int'(ifa.byte_strobe), 0);
    check({name, "_data"}, int'(ifa.data_out), int'(data_exp));
  endtask

  initial begin
    // basic lock and data, SYNC_COUNT = 4
    vecs[0]  = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[1]  = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[2]  = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[3]  = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b1, 0};
    vecs[4]  = '{8'h01, 1'b1, 8'h01, 1'b1, 1'b1, 0};
    vecs[5]  = '{8'h02, 1'b1, 8'h02, 1'b1, 1'b1, 0};
    vecs[6]  = '{8'hBC, 1'b1, 8'h02, 1'b0, 1'b1, 0};
    vecs[7]  = '{8'h03, 1'b1, 8'h03, 1'b1, 1'b1, 0};
    // 3-bit offset, interrupted comma run
    vecs[8]  = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[9]  = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[10] = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[11] = '{8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[12] = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[13] = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[14] = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[15] = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b1, 0};
    vecs[16] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b1, 0};
    // re-lock after enable drop
    vecs[17] = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[18] = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[19] = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[20] = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b1, 0};
    vecs[21] = '{8'h7E, 1'b1, 8'h7E, 1'b1, 1'b1, 0};
    // lock before slip sequence
    vecs[22] = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[23] = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[24] = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[25] = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b1, 0};
    // lock before async reset
    vecs[26] = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[27] = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[28] = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[29] = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b1, 0};
    vecs[30] = '{8'h01, 1'b1, 8'h01, 1'b1, 1'b1, 0};
    // second lane, SYNC_COUNT = 2
    vecs[31] = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 1};
    vecs[32] = '{8'hBC, 1'b0, 8'h00, 1'b0, 1'b1, 1};
    vecs[33] = '{8'h11, 1'b1, 8'h11, 1'b1, 1'b1, 1};

    reset_L    = 1'b0;
    ifa.enable = 1'b0;
    ifa.rx_in  = 1'b0;
    ifb.enable = 1'b0;
    ifb.rx_in  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle0("reset", 8'h00);
    reset_L    = 1'b1;
    ifa.enable = 1'b1;

    run_vecs(0, 7);

    disable_lane0(1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b0);
    send_bit(0, 1'b0);
    run_vecs(8, 16);

    // enable dropped 3 bits into a data frame
    send_bit(0, 1'b0);
    send_bit(0, 1'b0);
    send_bit(0, 1'b0);
    ifa.enable = 1'b0;
    ifa.rx_in  = 1'b1;
    @(posedge clk);
    #1;
    check_idle0("en_drop", 8'hA5);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check_idle0("en_held", 8'hA5);
    ifa.enable = 1'b1;
    run_vecs(17, 21);

    // enable low on the same edge as a byte completion
    for (int i = 7; i >= 1; i--) send_bit(0, i[0]);
    ifa.enable = 1'b0;
    send_bit(0, 1'b1);
    check_idle0("en_vs_byte", 8'h7E);
    ifa.enable = 1'b1;

    // one-bit slip then repeated commas
    run_vecs(22, 25);
    q0.push_back('{8'h5E, 1'b1});
    q0.push_back('{8'h5E, 1'b1});
    q0.push_back('{8'h5E, 1'b1});
    send_bit(0, 1'b0);
    send_byte(0, 8'hBC);
    send_byte(0, 8'hBC);
    check("slip_active_2nd", int'(ifa.active), 1);
    send_byte(0, 8'hBC);
    check("slip_active_3rd", int'(ifa.active), int'(LOS_ACTIVE_EXP));
    disable_lane0(1);

    // asynchronous reset mid-frame
    run_vecs(26, 30);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    ifa.rx_in = 1'b0;
    #3;
    reset_L = 1'b0;
    #1;
    check_idle0("async_rst", 8'h00);
    for (int i = 0; i < 4; i++) begin
      ifa.rx_in = i[0];
      @(posedge clk);
      #1;
    end
    ifa.rx_in = 1'b0;
    reset_L   = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    check_idle0("post_rst", 8'h00);

    ifb.enable = 1'b1;
    run_vecs(31, 33);

    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("pending0", q0.size(), 0);
    check("pending1", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_rx_lane.md
# serial_rx_lane

Single-lane PHY receiver and the counterpart of the two-lane serial transmitter. It samples one serial bit per `clk_8f` cycle, finds byte alignment by hunting for comma bytes, and reports lock after a run of aligned commas. Once locked, it converts each 8-bit frame into a parallel byte with a valid flag: comma frames are idle and all other frames are data. The PHY RX top instantiates one per lane, `rx_in` tied to the corresponding `tx_out_N`.

## Interface
- `COMMA`, 8'hBC: idle/alignment byte.
- `SYNC_COUNT`, 4: number of consecutive aligned commas required for lock (legal 2..15).
- `clk_8f` input 1: bit clock; all state changes on its rising edge.
- `reset_L` input 1: asynchronous, active-low reset.
- `enable` input 1: lane enable; low forces the receiver to SEARCH.
- `rx_in` input 1: serial data, MSB first, one bit per `clk_8f`.
- `data_out` output 8: last received data byte.
- `valid_out` output 1: high while `data_out` holds a byte from the current frame slot that was not a comma.
- `byte_strobe` output 1: one-cycle pulse at each byte boundary while ACTIVE.
- `active` output 1: high in ACTIVE (lane locked).

## Operation
- The shift register updates every enabled cycle: `sr <= {sr[6:0], rx_in}`. Comparisons use the next value `win = {sr[6:0], rx_in}`.
- 3-bit `bit_cnt` and 4-bit `comma_cnt` are internal.
- SEARCH:
  - Compare `win` to `COMMA` every cycle.
  - On a match: `bit_cnt <= 0`, `comma_cnt <= 1`, go to COUNT.
- COUNT:
  - `bit_cnt` increments mod 8.
  - When `bit_cnt == 7`, the byte is complete and `win` is checked.
  - `win == COMMA`: `comma_cnt + 1`. When that reaches `SYNC_COUNT`, go to ACTIVE.
  - `win != COMMA`: return to SEARCH with `comma_cnt <= 0`.
- ACTIVE, at each byte completion:
  - `byte_strobe <= 1`.
  - Comma: `valid_out <= 0` and `data_out` holds its value.
  - Otherwise: `data_out <= win`, `valid_out <= 1`.
  - Between completions: `byte_strobe <= 0` and `valid_out` holds.
- ACTIVE is left only by `enable` low, reset, or loss of sync (see Configuration).
- `enable` low, sampled on any edge:
  - Go to SEARCH.
  - `sr`, `bit_cnt` and `comma_cnt` clear.
  - `valid_out`, `byte_strobe` and `active` clear.
  - `data_out` holds.
  - No bits are shifted while `enable` is low.
- Reset values: state SEARCH, `sr = 0`, counters 0, `data_out = 8'h00`, `valid_out = 0`, `byte_strobe = 0`, `active = 0`.
- Reset mid-byte discards the partial frame. Lock must be re-acquired from SEARCH.

## Timing
- All outputs are registered.
- A byte's outputs update on the same edge that samples its 8th bit (LSB) and are visible from that edge on. `rx_in`-to-output latency is 1 edge after the last bit.
- `active` rises on the edge that samples the LSB of the `SYNC_COUNT`-th aligned comma. The first data byte can be the very next frame.
- `byte_strobe` period is exactly 8 cycles in ACTIVE. It is never asserted outside ACTIVE. It is not asserted on the locking comma itself.
- In SEARCH, a match is tested every cycle, so alignment is acquired at any bit offset.
- If enable low and a byte completion occur on the same edge, enable wins: no strobe, no data update.

## Configuration
- `SERIAL_RX_LOS_EN` defined: loss-of-sync detection in ACTIVE.
  - A `win == COMMA` match when `bit_cnt != 7` increments a 2-bit misalignment counter.
  - An aligned comma (at `bit_cnt == 7`) clears the counter.
  - When the counter would reach 3, the next edge returns to SEARCH. `active`, `valid_out` and `byte_strobe` clear. The counter resets.
  - Data bytes do not affect the counter.
- Not defined: no misalignment tracking. ACTIVE persists regardless of stream content.

## Test plan
- Reset asserted mid-stream, `rx_in` toggling → all outputs 0 immediately (asynchronous), and still 0 after release with `rx_in = 0`.
- `enable = 1`, stream BC,BC,BC,BC,01,02,BC,03 MSB first → `active` rises at the LSB of the 4th BC. Then:
  - `data_out/valid_out` = 01/1, then 02/1.
  - The BC frame gives 02/0.
  - The last frame gives 03/1.
  - `byte_strobe` pulses every 8 cycles.
- Three leading zero bits, then BC,BC,BC,55,BC×4,A5 → no lock after the 55; lock after the later 4 BCs at the 3-bit offset; `data_out = A5`, `valid_out = 1`.
- Locked, then `enable` dropped 3 bits into the 01 frame for 5 cycles, then restored with BC×4,7E → outputs clear and `data_out` holds its prior value. Re-lock occurs, then 7E/1 is output.
- `SERIAL_RX_LOS_EN` defined: lock, then delay the stream by 1 bit and send BC repeatedly → `active` drops after the 3rd misaligned comma match. Without the macro, `active` stays 1.
- `SYNC_COUNT = 2`: BC,BC,11 → `active` after the 2nd BC; `data_out = 11`, `valid_out = 1`.
